// File: rtl/draw_pkg.sv
// Shared types and helpers for the draw subsystem's paired-address path.
package draw_pkg;

   localparam int DRAW_IDX_W = 13;
   localparam int DRAW_LEN_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Pair address: index shifted up one bit with the even/odd selector in the LSB.
   // Callers truncate the result to IDX_W+1 bits.
   function automatic logic [31:0] pair_addr(input logic [30:0] idx, input logic odd);
      return {idx, odd};
   endfunction

endpackage

// File: rtl/draw_pair_sched_if.sv
// Requester, arbitration and pair-stream signals between the scheduler and its clients.
interface draw_pair_sched_if #(
   parameter int IDX_W = 13,
   parameter int LEN_W = 8
);
   logic [1:0]       req;
   logic [IDX_W-1:0] base0;
   logic [IDX_W-1:0] base1;
   logic [LEN_W-1:0] len0;
   logic [LEN_W-1:0] len1;
   logic [1:0]       gnt;
   logic             abort;
   logic [IDX_W:0]   Q_a;
   logic [IDX_W:0]   Q_b;
   logic             out_valid;
   logic             out_ready;
   logic             owner;
   logic             busy;
   logic [1:0]       done;

   modport master (
      output req, base0, base1, len0, len1, abort, out_ready,
      input  gnt, Q_a, Q_b, out_valid, owner, busy, done
   );

   modport slave (
      input  req, base0, base1, len0, len1, abort, out_ready,
      output gnt, Q_a, Q_b, out_valid, owner, busy, done
   );
endinterface

// File: rtl/draw_pair_counter.sv
// Loadable pair-index counter; presents the current index as an even/odd address pair.
module draw_pair_counter
   import draw_pkg::*;
#(
   parameter int IDX_W = DRAW_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [IDX_W-1:0] load_val,
   input  logic             en,
   output logic [IDX_W:0]   Q_a,
   output logic [IDX_W:0]   Q_b
);

   logic [IDX_W-1:0] idx;

   // Wrap past the top index is intentional and silent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     idx <= '0;
      else if (load) idx <= load_val;
      else if (en)   idx <= idx + 1'b1;
   end

   assign Q_a = (IDX_W+1)'(pair_addr(31'(idx), 1'b0));
   assign Q_b = (IDX_W+1)'(pair_addr(31'(idx), 1'b1));

endmodule

// File: rtl/draw_pair_sched.sv
// Round-robin scheduler sharing one pair-address generator between two sweep requesters.
module draw_pair_sched
   import draw_pkg::*;
#(
   parameter int IDX_W = DRAW_IDX_W,
   parameter int LEN_W = DRAW_LEN_W
) (
   input logic               clk,
   input logic               reset,
   draw_pair_sched_if.slave  bus
);

   state_t           state, nxt;
   logic             rr_ptr;
   logic             owner_q;
   logic [LEN_W:0]   remaining;
   logic [1:0]       gnt_q;
   logic             pick;
   logic             pick_id;
   logic             fire;
   logic [IDX_W-1:0] sel_base;
   logic [LEN_W-1:0] sel_len;

   assign fire     = (state == RUN) && bus.out_ready;
   assign sel_base = pick_id ? bus.base1 : bus.base0;
   assign sel_len  = pick_id ? bus.len1  : bus.len0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt     = state;
      pick    = 1'b0;
      pick_id = rr_ptr;
      case (state)
         IDLE: if (|bus.req) begin
            pick    = 1'b1;
            pick_id = (bus.req == 2'b11) ? rr_ptr : bus.req[1];
            nxt     = RUN;
         end
         // Abort takes priority even over a final transfer in the same cycle.
         RUN: begin
            if (bus.abort)                       nxt = IDLE;
            else if (fire && remaining == 'd1)   nxt = DONE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= 1'b0;
         owner_q   <= 1'b0;
         remaining <= '0;
         gnt_q     <= '0;
      end else begin
         gnt_q <= '0;
         if (pick) begin
            owner_q        <= pick_id;
            gnt_q[pick_id] <= 1'b1;
            // A zero length encodes the full 2^LEN_W sweep.
            remaining      <= (sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, sel_len};
         end else if (fire) begin
            remaining <= remaining - 1'b1;
         end
         if (state == DONE || (state == RUN && bus.abort))
            rr_ptr <= ~owner_q;
      end
   end

   draw_pair_counter #(.IDX_W(IDX_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (pick),
      .load_val (sel_base),
      .en       (fire),
      .Q_a      (bus.Q_a),
      .Q_b      (bus.Q_b)
   );

   assign bus.gnt       = gnt_q;
   assign bus.out_valid = (state == RUN);
   assign bus.owner     = owner_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
